seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, clocked successor to the lab1 6-bit combinational ALU. It supports add, sub, mul and div on WIDTH-bit operands with a start/done handshake. Add and sub complete in one cycle. Mul uses iterative shift-add and div uses restoring division, each taking WIDTH iterations, which removes the large combinational multiplier/divider. It sits between operand registers/switch inputs and the result display, and adds divide-by-zero reporting and a busy indication.

Parameters:
WIDTH, 6, operand width in bits (legal range 2..16); result width is 2*WIDTH.

Ports:
clk_in  input  1  clock; all logic is on the rising edge.
rst_in  input  1  synchronous, active-high reset.
start_in  input  1  request; sampled only when busy_out=0.
a_in  input  WIDTH  operand A; latched on an accepted start.
b_in  input  WIDTH  operand B; latched on an accepted start.
op_in  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div; latched on an accepted start.
busy_out  output  1  high while an operation is in progress.
done_out  output  1  one-cycle pulse when c_out and the flags become valid.
c_out  output  2*WIDTH  result, held until the next accepted start.
overflow_out  output  1  signed overflow for add/sub; see Optional Feature for mul.
divzero_out  output  1  set when a div had b=0.

Behaviour:
- Reset (rst_in=1 at a clock edge): state goes to IDLE. busy_out, done_out, c_out, overflow_out and divzero_out all become 0. This applies in any state, including mid-operation; the aborted operation produces no done_out.
- States: IDLE, RUN, FIN.
- Accept: start_in=1 while in IDLE or FIN latches a_in, b_in and op_in and clears both flags. start_in while in RUN is ignored (no queueing).
- Add/sub, start accepted at edge N:
  - Result registered at edge N+1; done_out=1 in cycle N+1; state goes to FIN.
  - busy_out never asserts.
  - c_out = {WIDTH zeros, WIDTH-bit sum or difference}, modulo 2^WIDTH.
  - Sub is computed as a + ~b + 1.
  - overflow_out is signed overflow: the operand sign bits (b inverted for sub) are equal and the result sign bit differs from them.
- Mul and div (b≠0), start accepted at edge N:
  - State goes to RUN and busy_out=1 from cycle N+1.
  - Iteration counter counts 0..WIDTH-1, one iteration per cycle.
  - The last iteration completes at edge N+WIDTH. At edge N+WIDTH+1 the result is registered, done_out=1, busy_out=0 and state goes to FIN.
  - Total latency is WIDTH+1 cycles.
- Mul: unsigned product, full 2*WIDTH bits; no truncation.
- Div: unsigned restoring division; c_out = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- Divide by zero (op=11, b=0):
  - Skips RUN; done_out=1 at edge N+1, like add/sub.
  - Quotient is all ones and remainder equals a.
  - divzero_out=1, overflow_out=0.
- FIN: done_out drops after one cycle. The state then behaves as IDLE, and c_out and the flags hold.
- Back-to-back: start_in=1 in the same cycle as done_out is accepted; done_out for that operation follows the normal latency.
- divzero_out is only ever 1 for div.

Optional Feature:
- Macro: SEQ_ALU_MUL_OVF_EN.
- Defined: for mul, overflow_out = OR of product bits [2*WIDTH-1:WIDTH], i.e. the product does not fit in WIDTH unsigned bits.
- Undefined: overflow_out=0 for mul, matching the lab1 behaviour.
- Div never sets overflow_out in either build.

Test Plan:
1. WIDTH=6, add a=31, b=1 -> done_out 1 cycle after start, c_out=0x020, overflow_out=1, busy_out never high.
2. WIDTH=6, sub a=32 (-32), b=1 -> c_out=0x01F, overflow_out=1. Then sub a=0, b=1 -> c_out=0x03F, overflow_out=0.
3. WIDTH=6, mul a=63, b=63 -> busy_out high for 6 cycles, done_out 7 cycles after start, c_out=0xF81. overflow_out=1 with SEQ_ALU_MUL_OVF_EN defined, 0 without.
4. WIDTH=6, div a=45, b=7 -> c_out=0x0C6 (r=3, q=6), done_out 7 cycles after start. A start_in pulsed during RUN is ignored and the result is unchanged.
5. WIDTH=6, div a=13, b=0 -> done_out after 1 cycle, c_out=0x37F, divzero_out=1, overflow_out=0.
6. Assert rst_in in the 3rd RUN cycle of a mul -> next cycle busy_out=0, c_out=0, no done_out pulse. A new add 2+3 then gives c_out=0x005.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: clocked add/sub/mul/div unit with a start/done handshake.
// Add, sub and divide-by-zero finish one cycle after the start is taken.
// Mul (shift-add) and div (restoring) iterate once per bit, busy_out high.
// Build option: define SEQ_ALU_MUL_OVF_EN to flag mul products that do not
// fit in WIDTH unsigned bits; otherwise overflow_out stays 0 for mul.
//
// Handshake: start_in is taken when the unit is idle (IDLE or FIN, and no
// launch in flight); operands are latched at that edge. Exactly one
// done_out pulse follows per taken start unless rst_in aborts it. c_out and
// the flags are valid from the done_out cycle and hold until the next result.
module seq_alu #(
  parameter int WIDTH = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [1:0]         op_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [2*WIDTH-1:0] c_out,
  output logic               overflow_out,
  output logic               divzero_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t state, state_nx;

  // pend marks the launch cycle right after a taken start
  logic               pend;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [1:0]         op_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH-1:0]   mplier, rem, quo;

  logic               accept, long_op, last;
  logic [WIDTH-1:0]   b_eff, sum;
  logic               add_ovf, mul_ovf;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [WIDTH-1:0]   rem_nx, quo_nx;

  assign accept  = start_in && (state != RUN) && !pend;
  // mul, or div with a non-zero divisor, needs the iterative RUN phase
  assign long_op = op_r[1] && !(op_r[0] && (b_r == '0));
  assign last    = (cnt == CW'(WIDTH - 1));

  // add/sub: sub is a + ~b + 1; signed overflow from operand/result signs
  always_comb begin
    b_eff   = op_r[0] ? ~b_r : b_r;
    sum     = a_r + b_eff + {{(WIDTH-1){1'b0}}, op_r[0]};
    add_ovf = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
  end

  // one shift-add step and one restoring-division step per RUN cycle
  always_comb begin
    prod_nx  = prod + (mplier[0] ? mcand : '0);
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_r};
    if (rem_sh >= {1'b0, b_r}) begin
      rem_nx = rem_diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
`ifdef SEQ_ALU_MUL_OVF_EN
    mul_ovf = |prod_nx[2*WIDTH-1:WIDTH];
`else
    mul_ovf = 1'b0;
`endif
  end

  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: if (pend) state_nx = long_op ? RUN : FIN;
      RUN:       if (last) state_nx = FIN;
      default:   state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy_out = (state == RUN);
  end

  // operand latch, iteration registers and result/flag registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend         <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      op_r         <= '0;
      cnt          <= '0;
      prod         <= '0;
      mcand        <= '0;
      mplier       <= '0;
      rem          <= '0;
      quo          <= '0;
      done_out     <= 1'b0;
      c_out        <= '0;
      overflow_out <= 1'b0;
      divzero_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      pend     <= accept;
      if (accept) begin
        a_r          <= a_in;
        b_r          <= b_in;
        op_r         <= op_in;
        overflow_out <= 1'b0;
        divzero_out  <= 1'b0;
      end
      if (pend) begin
        cnt    <= '0;
        prod   <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_r};
        mplier <= b_r;
        rem    <= '0;
        quo    <= a_r;
        if (!op_r[1]) begin
          c_out        <= {{WIDTH{1'b0}}, sum};
          overflow_out <= add_ovf;
          done_out     <= 1'b1;
        end else if (op_r[0] && (b_r == '0)) begin
          c_out       <= {a_r, {WIDTH{1'b1}}};
          divzero_out <= 1'b1;
          done_out    <= 1'b1;
        end
      end
      if (state == RUN) begin
        cnt    <= cnt + 1'b1;
        prod   <= prod_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        rem    <= rem_nx;
        quo    <= quo_nx;
        if (last) begin
          done_out <= 1'b1;
          if (op_r[0]) begin
            c_out <= {rem_nx, quo_nx};
          end else begin
            c_out        <= prod_nx;
            overflow_out <= mul_ovf;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu at WIDTH=6 with hand-computed
// results, latencies, busy counts and flags.
module tb_seq_alu;

  localparam int W = 6;
`ifdef SEQ_ALU_MUL_OVF_EN
  localparam logic MOVF = 1'b1;
`else
  localparam logic MOVF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, start;
  logic [W-1:0]   a, b;
  logic [1:0]     op;
  logic           busy, done, ovf, dz;
  logic [2*W-1:0] c;

  logic [2*W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .a_in(a), .b_in(b), .op_in(op),
    .busy_out(busy), .done_out(done), .c_out(c),
    .overflow_out(ovf), .divzero_out(dz)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation and check its latency, busy cycles, result and flags.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [1:0] top, input logic [2*W-1:0] ec,
                        input logic eo, input logic ed, input int elat, input int ebusy,
                        input bit b2b, input bit poke);
    int lat, busy_n;
    logic [2*W-1:0] exp_c;
    if (!b2b) begin
      @(posedge clk); #1;
      check({tag, ".prev_done_low"}, 32'(done), 32'd0);
    end
    a = ta; b = tb; op = top; start = 1'b1;
    exp_q.push_back(ec);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom_range(0, (1 << W) - 1));
    b = W'($urandom_range(0, (1 << W) - 1));
    op = 2'($urandom_range(0, 3));
    lat = 0;
    busy_n = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
      if (done) break;
      if (poke && lat == 3) begin
        a = 6'd1; b = 6'd1; op = 2'b00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_c = exp_q.pop_front();
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(ebusy));
    check({tag, ".c"}, 32'(c), 32'(exp_c));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check({tag, ".divzero"}, 32'(dz), 32'(ed));
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.c", 32'(c), 32'd0);
    check("reset.ovf", 32'(ovf), 32'd0);
    check("reset.divzero", 32'(dz), 32'd0);
    rst = 1'b0;

    run_op("add_31_1",  6'd31, 6'd1,  2'b00, 12'h020, 1'b1, 1'b0, 1, 0, 0, 0);
    run_op("sub_32_1",  6'd32, 6'd1,  2'b01, 12'h01F, 1'b1, 1'b0, 1, 0, 0, 0);
    run_op("sub_0_1",   6'd0,  6'd1,  2'b01, 12'h03F, 1'b0, 1'b0, 1, 0, 0, 0);
    run_op("add_32_32", 6'd32, 6'd32, 2'b00, 12'h000, 1'b1, 1'b0, 1, 0, 0, 0);
    run_op("mul_63_63", 6'd63, 6'd63, 2'b10, 12'hF81, MOVF, 1'b0, 7, 6, 0, 0);
    run_op("div_45_7",  6'd45, 6'd7,  2'b11, 12'h0C6, 1'b0, 1'b0, 7, 6, 0, 1);
    run_op("div_13_0",  6'd13, 6'd0,  2'b11, 12'h37F, 1'b0, 1'b1, 1, 0, 0, 0);
    run_op("div_5_9",   6'd5,  6'd9,  2'b11, 12'h140, 1'b0, 1'b0, 7, 6, 0, 0);
    run_op("mul_63_63b",6'd63, 6'd63, 2'b10, 12'hF81, MOVF, 1'b0, 7, 6, 0, 0);

    // abort a mul with reset in its third RUN cycle
    @(posedge clk); #1;
    a = 6'd63; b = 6'd63; op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.c", 32'(c), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    check("abort.busy_after", 32'(busy), 32'd0);

    run_op("add_2_3",   6'd2,  6'd3,  2'b00, 12'h005, 1'b0, 1'b0, 1, 0, 0, 0);
    run_op("b2b_mul_5_9", 6'd5, 6'd9, 2'b10, 12'h02D, 1'b0, 1'b0, 7, 6, 1, 0);
    run_op("b2b_div_63_1", 6'd63, 6'd1, 2'b11, 12'h03F, 1'b0, 1'b0, 7, 6, 1, 0);
    @(posedge clk); #1;
    check("final.done_low", 32'(done), 32'd0);
    check("final.c_hold", 32'(c), 32'h03F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
